// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller for a simple in-order pipeline.
//
// This block decodes the MEM-stage instruction. Loads and stores start a
// memory handshake and stall the upstream pipeline until it completes.
// beq/bne/j are resolved combinationally and never stall.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   valid_in      MEM-stage instruction valid
//   opcode        6-bit MIPS-style opcode
//   zero          ALU zero flag of the same instruction
//   alu_result    effective address
//   store_data    store operand
//   mem_req/we    registered memory request / write enable
//   mem_addr      address latched at issue
//   mem_wdata     store data latched at issue
//   mem_ack       memory completion; mem_rdata is valid in the same cycle
//   mem_rdata     read data
//   stall         holds the upstream pipeline
//   load_data     captured read data (0 after a timeout)
//   load_valid    one-cycle pulse when load_data is valid
//   branch_taken  resolved beq/bne
//   jump          j instruction
//   mem_err       one-cycle pulse when a request times out
module mem_stage_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [5:0]        opcode,
    input  logic              zero,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic              branch_taken,
    output logic              jump,
    output logic              mem_err
);

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;

    // The counter holds the number of REQ cycles already spent without an
    // ack. When it reaches this value, the current REQ cycle is the last one.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       is_load_reg;

    logic is_lw;
    logic is_sw;
    logic idle_valid;
    logic start;

    assign is_lw      = (opcode == OP_LW);
    assign is_sw      = (opcode == OP_SW);
    assign idle_valid = valid_in && (state_reg == IDLE);
    assign start      = idle_valid && (is_lw || is_sw);

    // stall rises in the issue cycle, before the FSM has left IDLE. This
    // freezes the upstream pipeline without a one-cycle bubble.
    assign stall = start || (state_reg == REQ);

    assign branch_taken = idle_valid &&
                          (((opcode == OP_BEQ) && zero) ||
                           ((opcode == OP_BNE) && !zero));
    assign jump         = idle_valid && (opcode == OP_J);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            is_load_reg <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            // load_valid and mem_err are single-cycle pulses. Each one is
            // set only on the REQ->DONE edge, so it is high only in DONE.
            load_valid <= 1'b0;
            mem_err    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mem_addr    <= alu_result;
                        mem_wdata   <= store_data;
                        mem_we      <= is_sw;
                        is_load_reg <= is_lw;
                        cnt_reg     <= '0;
                        mem_req     <= 1'b1;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    // The ack is checked first, so a completion that lands
                    // in the last allowed cycle is not reported as a timeout.
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        load_valid <= is_load_reg;
                        if (is_load_reg) begin
                            load_data <= mem_rdata;
                        end
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        mem_req    <= 1'b0;
                        mem_err    <= 1'b1;
                        load_data  <= '0;
                        load_valid <= is_load_reg;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl (TIMEOUT=4). A timeline model predicts every
// output on every cycle, and per-scenario literal totals pin the model.
module tb_mem_stage_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [5:0]    opcode;
    logic          zero;
    logic [AW-1:0] alu_result;
    logic [DW-1:0] store_data;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          stall;
    logic [DW-1:0] load_data;
    logic          load_valid, branch_taken, jump, mem_err;

    mem_stage_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .opcode(opcode),
        .zero(zero), .alu_result(alu_result), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .branch_taken(branch_taken), .jump(jump), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A memory operation is described by how many REQ cycles have elapsed.
    // The DONE cycle follows the ack, or follows the TO-th unanswered cycle.
    logic          started = 1'b0;
    logic          m_busy, m_done, m_load, m_tmo;
    int            m_elapsed;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ldata;

    always @(posedge clk) begin
        if (rst) begin
            started = 1'b1;
            m_busy = 0; m_done = 0; m_load = 0; m_tmo = 0; m_elapsed = 0;
            m_we = 0; m_addr = '0; m_wdata = '0; m_ldata = '0;
        end else if (m_busy) begin
            m_elapsed++;
            if (mem_ack) begin
                m_busy = 0; m_done = 1; m_tmo = 0;
                if (m_load) m_ldata = mem_rdata;
            end else if (m_elapsed == TO) begin
                m_busy = 0; m_done = 1; m_tmo = 1; m_ldata = '0;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (valid_in && (opcode == LW || opcode == SW)) begin
            m_busy = 1; m_elapsed = 0;
            m_load = (opcode == LW); m_we = (opcode == SW);
            m_addr = alu_result; m_wdata = store_data;
        end
    end

    // Per-scenario tallies, cleared by the driver.
    int stall_n, req_n, lv_n, err_n;
    logic [AW-1:0] seen_addr;
    logic [DW-1:0] seen_wdata, seen_ldata;
    logic          seen_we;

    always @(negedge clk) begin
        if (started) begin
            logic idle_v, e_stall, e_bt, e_j;
            idle_v  = valid_in && !m_busy && !m_done;
            e_stall = m_busy || (idle_v && (opcode == LW || opcode == SW));
            e_bt    = idle_v && ((opcode == BEQ && zero) || (opcode == BNE && !zero));
            e_j     = idle_v && (opcode == JMP);
            chk("mem_req",      64'(mem_req),      64'(m_busy));
            chk("stall",        64'(stall),        64'(e_stall));
            chk("branch_taken", 64'(branch_taken), 64'(e_bt));
            chk("jump",         64'(jump),         64'(e_j));
            chk("load_valid",   64'(load_valid),   64'(m_done && m_load));
            chk("mem_err",      64'(mem_err),      64'(m_done && m_tmo));
            chk("mem_we",       64'(mem_we),       64'(m_we));
            chk("mem_addr",     64'(mem_addr),     64'(m_addr));
            chk("mem_wdata",    64'(mem_wdata),    64'(m_wdata));
            chk("load_data",    64'(load_data),    64'(m_ldata));
            stall_n += int'(stall);
            req_n   += int'(mem_req);
            lv_n    += int'(load_valid);
            err_n   += int'(mem_err);
            if (mem_req) begin
                seen_addr = mem_addr; seen_wdata = mem_wdata; seen_we = mem_we;
            end
            if (load_valid) seen_ldata = load_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tally();
        stall_n = 0; req_n = 0; lv_n = 0; err_n = 0;
        seen_addr = '0; seen_wdata = '0; seen_ldata = '0; seen_we = 1'b0;
    endtask

    // Issue op for one cycle. ack_at = REQ cycle carrying mem_ack (0 = never).
    // With noise set, a taken-looking beq is presented while the request waits.
    task automatic mem_op(input logic [5:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int ack_at,
                          input logic [DW-1:0] rd, input logic noise);
        clear_tally();
        valid_in = 1; opcode = op; alu_result = a; store_data = d;
        step();
        valid_in = noise; opcode = noise ? BEQ : ADDI; zero = 1;
        alu_result = 32'hFFFF_FFFF; store_data = 32'h1234_5678;
        if (ack_at > 0) begin
            for (int i = 1; i < ack_at; i++) step();
            mem_ack = 1; mem_rdata = rd;
            step();
            mem_ack = 0; mem_rdata = 32'hBAD0_BAD0; valid_in = 0;
            repeat (3) step();
        end else begin
            repeat (TO + 4) step();
            valid_in = 0;
        end
    endtask

    task automatic literal(input string name, input int act, input int exp);
        chk(name, 64'(act), 64'(exp));
        $display("txn %s: got %0d expected %0d", name, act, exp);
    endtask

    initial begin
        rst = 1; valid_in = 0; opcode = ADDI; zero = 0; alu_result = '0;
        store_data = '0; mem_ack = 0; mem_rdata = '0;
        clear_tally();
        repeat (2) step();
        rst = 0;
        @(negedge clk);
        chk("reset mem_req",   64'(mem_req),   64'd0);
        chk("reset stall",     64'(stall),     64'd0);
        chk("reset mem_addr",  64'(mem_addr),  64'd0);
        chk("reset load_data", 64'(load_data), 64'd0);
        chk("reset mem_err",   64'(mem_err),   64'd0);
        $display("txn reset: done");
        step();

        // lw @0x100, ack in 3rd REQ cycle
        mem_op(LW, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1'b1);
        literal("lw req cycles", req_n, 3);
        literal("lw stall cycles", stall_n, 4);
        literal("lw load_valid", lv_n, 1);
        chk("lw addr", 64'(seen_addr), 64'h100);
        chk("lw we", 64'(seen_we), 64'd0);
        chk("lw data", 64'(seen_ldata), 64'hDEADBEEF);

        // sw @0x20, ack in 1st REQ cycle
        mem_op(SW, 32'h20, 32'h5A5A5A5A, 1, 32'h0, 1'b0);
        literal("sw req cycles", req_n, 1);
        literal("sw stall cycles", stall_n, 2);
        literal("sw load_valid", lv_n, 0);
        chk("sw addr", 64'(seen_addr), 64'h20);
        chk("sw we", 64'(seen_we), 64'd1);
        chk("sw wdata", 64'(seen_wdata), 64'h5A5A5A5A);

        // lw with no ack: timeout
        mem_op(LW, 32'h44, 32'h0, 0, 32'h0, 1'b0);
        literal("tmo req cycles", req_n, 4);
        literal("tmo stall cycles", stall_n, 5);
        literal("tmo mem_err", err_n, 1);
        literal("tmo load_valid", lv_n, 1);
        chk("tmo load_data", 64'(load_data), 64'd0);

        // ack on the last allowed cycle wins over timeout
        mem_op(LW, 32'h80, 32'h0, 4, 32'hCAFEF00D, 1'b0);
        literal("edge req cycles", req_n, 4);
        literal("edge mem_err", err_n, 0);
        chk("edge data", 64'(seen_ldata), 64'hCAFEF00D);

        // sw with no ack: error pulse, no load_valid
        mem_op(SW, 32'h90, 32'h11112222, 0, 32'h0, 1'b0);
        literal("sw tmo mem_err", err_n, 1);
        literal("sw tmo load_valid", lv_n, 0);

        // reset in 2nd REQ cycle, followed by a late ack
        clear_tally();
        valid_in = 1; opcode = LW; alu_result = 32'h300;
        step();
        valid_in = 0; opcode = ADDI;
        step();
        rst = 1;
        step();
        rst = 0; mem_ack = 1; mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("rst next mem_req", 64'(mem_req), 64'd0);
        chk("rst next stall", 64'(stall), 64'd0);
        step();
        mem_ack = 0;
        repeat (3) step();
        literal("rst req cycles", req_n, 2);
        literal("rst load_valid", lv_n, 0);
        literal("rst mem_err", err_n, 0);

        // branches and jumps, sampled in the same cycle
        valid_in = 1; opcode = BEQ; zero = 1;
        @(negedge clk);
        chk("beq z=1 taken", 64'(branch_taken), 64'd1);
        chk("beq stall", 64'(stall), 64'd0);
        step(); opcode = BNE; zero = 1;
        @(negedge clk);
        chk("bne z=1 taken", 64'(branch_taken), 64'd0);
        step(); opcode = BNE; zero = 0;
        @(negedge clk);
        chk("bne z=0 taken", 64'(branch_taken), 64'd1);
        step(); opcode = JMP;
        @(negedge clk);
        chk("j jump", 64'(jump), 64'd1);
        chk("j mem_req", 64'(mem_req), 64'd0);
        step(); opcode = 6'b111111; zero = 1;
        @(negedge clk);
        chk("op3f jump", 64'(jump), 64'd0);
        chk("op3f branch", 64'(branch_taken), 64'd0);
        chk("op3f stall", 64'(stall), 64'd0);
        $display("txn branch/jump: done");
        step();

        // stray ack in IDLE is ignored
        clear_tally();
        valid_in = 0; mem_ack = 1; mem_rdata = 32'h55555555;
        repeat (2) step();
        mem_ack = 0;
        step();
        literal("idle ack load_valid", lv_n, 0);
        literal("idle ack req", req_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: memory address width.
REQ-002 Parameter DATA_W, default 32: memory data width.
REQ-003 Parameter TIMEOUT, default 15: maximum REQ cycles without mem_ack; legal range 1..255.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 valid_in  input  1  MEM-stage instruction valid.
REQ-008 opcode  input  6  MEM-stage opcode.
REQ-009 zero  input  1  ALU zero flag of the same instruction.
REQ-010 alu_result  input  ADDR_W  effective address.
REQ-011 store_data  input  DATA_W  store operand.
REQ-012 mem_req  output  1  memory request, registered.
REQ-013 mem_we  output  1  1 = write, 0 = read, registered.
REQ-014 mem_addr  output  ADDR_W  latched address.
REQ-015 mem_wdata  output  DATA_W  latched store data.
REQ-016 mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
REQ-017 mem_rdata  input  DATA_W  read data.
REQ-018 stall  output  1  holds the upstream pipeline.
REQ-019 load_data  output  DATA_W  captured read data.
REQ-020 load_valid  output  1  one-cycle pulse when load_data is valid.
REQ-021 branch_taken  output  1  resolved beq/bne.
REQ-022 jump  output  1  j instruction.
REQ-023 mem_err  output  1  one-cycle timeout pulse.

Function
REQ-024 Decode SHALL be as follows:
- lw 100011 = load.
- sw 101011 = store.
- beq 000100 = branch if zero.
- bne 000101 = branch if !zero.
- j 000010 = jump.
- R-type 000000, addi, ori, andi, slti, and any other opcode = no action.
REQ-025 branch_taken and jump SHALL be combinational, and asserted only when valid_in=1 and state=IDLE.
REQ-026 The FSM SHALL have the states IDLE, REQ, DONE.
REQ-027 IDLE: when valid_in and the opcode is load or store, the block SHALL:
- assert stall combinationally in the same cycle;
- latch alu_result, store_data and mem_we;
- clear the timeout counter;
- go to REQ, with mem_req=1 from the next cycle.
REQ-028 REQ: mem_req and stall SHALL stay 1, with mem_addr, mem_wdata and mem_we stable, until mem_ack.
REQ-029 REQ with mem_ack=1 SHALL:
- go to DONE;
- for a load, capture mem_rdata into load_data.
REQ-030 REQ without mem_ack SHALL increment the counter; when the counter reaches TIMEOUT-1 with no ack, the block SHALL pulse mem_err on the transition edge, set load_data=0 and go to DONE.
REQ-031 When mem_ack and timeout coincide, ack SHALL win and mem_err SHALL stay 0.
REQ-032 DONE SHALL:
- drive stall=0 and mem_req=0;
- pulse load_valid=1 only for a load;
- go to IDLE next cycle.
REQ-033 mem_ack outside REQ SHALL be ignored.
REQ-034 Load/store latency: stall SHALL be high for 1 + N cycles, where N = REQ cycles up to and including the ack cycle.
REQ-035 Branch and jump instructions SHALL never assert stall or mem_req.

Reset
REQ-036 rst=1 at a clock edge SHALL force:
- state IDLE;
- mem_req, mem_we, load_valid, mem_err = 0;
- mem_addr, mem_wdata, load_data, counter = 0.
REQ-037 Reset SHALL take priority over every other event, including a mid-REQ ack; a transaction aborted by reset SHALL produce no load_valid and no mem_err.

Verification
REQ-038 lw, valid_in=1, alu_result=0x100, mem_ack in the 3rd REQ cycle with mem_rdata=0xDEADBEEF -> required response:
- mem_req=1 for 3 cycles, mem_we=0, mem_addr=0x100;
- stall=1 for 4 cycles;
- load_valid single pulse with load_data=0xDEADBEEF.
REQ-039 sw, alu_result=0x20, store_data=0x5A5A5A5A, ack in the 1st REQ cycle -> required response:
- mem_we=1, mem_wdata=0x5A5A5A5A, mem_addr=0x20;
- stall=1 for 2 cycles;
- load_valid=0.
REQ-040 beq with zero=1 -> branch_taken=1 in the same cycle; bne with zero=1 -> branch_taken=0; neither case asserts stall or mem_req.
REQ-041 TIMEOUT=4, lw with no mem_ack -> required response:
- mem_req=1 for exactly 4 cycles;
- mem_err single pulse;
- load_data=0, load_valid pulse;
- return to IDLE.
REQ-042 rst=1 during the 2nd REQ cycle, followed by a late mem_ack -> required response:
- mem_req=0 and stall=0 the next cycle;
- ack ignored;
- no load_valid or mem_err.
REQ-043 j -> jump=1; opcode 111111 -> branch_taken, jump, stall and mem_req all 0.
